quiz_host: RTL
==============

QUIZ_HOST -- requirements
Module: quiz_host

Interface
REQ-001 The block SHALL have parameter ROUND_CYC, default 100, meaning the number of ARMED cycles before an unanswered round is voided.
REQ-002 The block SHALL have parameter MAX_SCORE, default 9, meaning the per-contestant score saturation value (at most 15).
REQ-003 The block SHALL have parameter ALARM_CYC, default 4, meaning the alarm pulse length in cycles.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_round  input  1  moderator one-cycle pulse (pre-debounced) that opens or aborts a round.
REQ-007 btn_ok  input  1  moderator one-cycle pulse: the answer is correct.
REQ-008 btn_ng  input  1  moderator one-cycle pulse: the answer is wrong.
REQ-009 lamp_n  input  4  judge lamp outputs, active low; bit0 is contestant 1 and bit3 is contestant 4.
REQ-010 buzz_n  input  1  judge answer-timeout signal, active low.
REQ-011 start  output  1  judge arm; 0 holds the judge cleared and 1 enables buzzing-in.
REQ-012 winner  output  3  latched contestant number: 0 means none, 1-4 name a contestant.
REQ-013 score  output  16  packed 4-bit scores: [3:0] contestant 1 through [15:12] contestant 4.
REQ-014 alarm  output  1  active-high piezo pulse.
REQ-015 state  output  3  FSM state code: IDLE=0, ARMED=1, LOCKED=2, CLEAR=3.

Function
REQ-016 In IDLE, start SHALL be 0; btn_round=1 SHALL move the FSM to ARMED on that edge, clear winner to 0 and clear the round counter.
REQ-017 In ARMED, start SHALL be 1 and the round counter SHALL increment once per cycle.
REQ-018 In ARMED, the first edge sampling any lamp_n bit at 0 SHALL latch winner as the lowest-index low bit (lamp_n=4'b0101 gives winner=2) and SHALL move the FSM to LOCKED on that same edge.
REQ-019 In ARMED, when the counter reaches ROUND_CYC-1 with no lamp low, the FSM SHALL enter CLEAR with winner=0 and SHALL fire alarm.
REQ-020 In ARMED, btn_round=1 SHALL abort the round: the FSM enters CLEAR, winner=0, no score changes and no alarm; btn_round takes priority over a lamp sampled on the same edge.
REQ-021 In LOCKED, start SHALL stay 1 and winner SHALL hold, even after lamp_n returns to 4'b1111.
REQ-022 In LOCKED, btn_ok alone SHALL increment score[winner], saturating at MAX_SCORE, and the FSM SHALL enter CLEAR.
REQ-023 In LOCKED, btn_ng alone, or buzz_n=0, SHALL apply the penalty rule of REQ-033/034 and the FSM SHALL enter CLEAR; buzz_n=0 additionally SHALL fire alarm.
REQ-024 In LOCKED, btn_ok and btn_ng asserted on the same edge SHALL be ignored, and the FSM SHALL remain in LOCKED.
REQ-025 If btn_ok and buzz_n=0 occur on the same edge, btn_ok SHALL win and no alarm SHALL fire.
REQ-026 In LOCKED, btn_round SHALL be ignored.
REQ-027 CLEAR SHALL last exactly 2 cycles with start=0, then the FSM SHALL return to IDLE; all button inputs are ignored during CLEAR.
REQ-028 The score update SHALL be registered on the decision edge, so the new score is visible the following cycle.
REQ-029 An alarm firing SHALL drive alarm=1 for exactly ALARM_CYC cycles starting the cycle after the firing edge; a new firing during a pulse SHALL restart the count.
REQ-030 btn_ok and btn_ng outside LOCKED SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL, asynchronously, force state=IDLE, start=0, winner=0, score=16'h0000, alarm=0, and clear the round and alarm counters.
REQ-032 Reset asserted mid-round SHALL discard the round without any score change, and after release the FSM SHALL start in IDLE.

Configuration
REQ-033 With macro QUIZ_PENALTY_EN defined, a wrong answer or timeout in LOCKED SHALL decrement score[winner], saturating at 0.
REQ-034 Without QUIZ_PENALTY_EN, a wrong answer or timeout SHALL leave the score unchanged; all other behaviour is identical.

Verification
REQ-035 Reset, btn_round, lamp_n=4'b1011 for 3 cycles, then btn_ok -> winner=3, score=16'h0100, CLEAR held 2 cycles with start=0, then IDLE.
REQ-036 btn_round then lamp_n=4'b1111 for ROUND_CYC cycles -> CLEAR entered, winner=0, alarm=1 for exactly 4 cycles, score unchanged.
REQ-037 Contestant 1 winning ten rounds in a row, each ended by btn_ok -> score[3:0] saturates at 9.
REQ-038 With QUIZ_PENALTY_EN: winner=2 and score 0, then buzz_n=0 -> score stays 0 and alarm fires; a second round scored ok then ng -> score[7:4]=0. Without the macro: ok then ng -> score[7:4]=1.
REQ-039 In LOCKED, btn_ok and btn_ng on the same cycle -> FSM stays LOCKED; in ARMED, btn_round and lamp_n=4'b1110 on the same cycle -> CLEAR with winner=0.
REQ-040 rst_n pulsed low for 1 cycle while LOCKED with score nonzero -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/quiz_host.sv
// quiz_host: quiz moderator FSM with judge arming, scoring, alarm; define QUIZ_PENALTY_EN to decrement on wrong/timeout
module quiz_host #(
  parameter int ROUND_CYC = 100,
  parameter int MAX_SCORE = 9,
  parameter int ALARM_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_round,
  input  logic        btn_ok,
  input  logic        btn_ng,
  input  logic [3:0]  lamp_n,
  input  logic        buzz_n,
  output logic        start,
  output logic [2:0]  winner,
  output logic [15:0] score,
  output logic        alarm,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, LOCKED = 3'd2, CLEAR = 3'd3} st_t;
  localparam int CW = ROUND_CYC > 1 ? $clog2(ROUND_CYC) : 1;
  localparam int AW = $clog2(ALARM_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUND_CYC - 1);
  localparam logic [3:0] MAXS = 4'(MAX_SCORE);
  st_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW-1:0] acnt;
  logic clr, clr_nx, fire;
  logic [2:0] win_nx, first;
  logic [15:0] sc_nx;
  logic [1:0] wi;
  logic [3:0] cur;
  assign wi = 2'(winner - 3'd1);
  assign cur = score[{wi, 2'b00} +: 4];
  assign first = !lamp_n[0] ? 3'd1 : !lamp_n[1] ? 3'd2 : !lamp_n[2] ? 3'd3 : 3'd4;
  assign start = st == ARMED || st == LOCKED;
  assign alarm = acnt != '0;
  assign state = st;
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    clr_nx = 1'b0;
    win_nx = winner;
    sc_nx = score;
    fire = 1'b0;
    case (st)
      IDLE: if (btn_round) begin
        st_nx = ARMED;
        win_nx = '0;
        cnt_nx = '0;
      end
      ARMED: begin
        cnt_nx = cnt + CW'(1);
        if (btn_round) begin
          st_nx = CLEAR;
          win_nx = '0;
        end else if (lamp_n != 4'hf) begin
          st_nx = LOCKED;
          win_nx = first;
        end else if (cnt == LAST) begin
          st_nx = CLEAR;
          win_nx = '0;
          fire = 1'b1;
        end
      end
      LOCKED: if (btn_ok && !btn_ng) begin
        sc_nx[{wi, 2'b00} +: 4] = cur >= MAXS ? cur : cur + 4'd1;
        st_nx = CLEAR;
      end else if ((btn_ng && !btn_ok) || !buzz_n) begin
`ifdef QUIZ_PENALTY_EN
        sc_nx[{wi, 2'b00} +: 4] = cur == 4'd0 ? 4'd0 : cur - 4'd1;
`endif
        st_nx = CLEAR;
        fire = !buzz_n;
      end
      CLEAR: begin
        clr_nx = !clr;
        st_nx = clr ? IDLE : CLEAR;
      end
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      clr <= 1'b0;
      acnt <= '0;
      winner <= '0;
      score <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      clr <= clr_nx;
      winner <= win_nx;
      score <= sc_nx;
      acnt <= fire ? AW'(ALARM_CYC) : acnt - AW'(acnt != '0);
    end
endmodule
